// File: rtl/somador_pkg.sv
// Shared constants and types for the pipelined 8-bit adder core.
// Latency: not applicable (declarations only).
// Backpressure: not applicable (declarations only).
package somador_pkg;

   localparam int WIDTH_DEF   = 8;  // operand and sum width
   localparam int SPLIT_DEF   = 4;  // low-slice width added in stage 1
   localparam int LATENCY     = 3;  // input edge to visible result, in clock edges
   localparam int FILL_PRIMED = 2;  // fill count at which outputs are released

   // Pipeline priming progress after reset release; PRIMED holds until reset.
   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FILL1  = 2'd1,
      PRIMED = 2'(FILL_PRIMED)
   } fill_state_t;

endpackage

// File: rtl/somador_if.sv
// Operand/result bundle between the pad ring and the adder core.
// Latency: wires only, no storage.
// Backpressure: none; a new operand set is accepted every cycle.
// Signals: a_i, b_i, carry_i (operands into the core); sum_o, carry_o (results out).
interface somador_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             carry_i;
   logic [WIDTH-1:0] sum_o;
   logic             carry_o;

   // Pad-ring side: drives operands, observes results.
   modport master (
      output a_i,
      output b_i,
      output carry_i,
      input  sum_o,
      input  carry_o
   );

   // Core side: consumes operands, drives results.
   modport slave (
      input  a_i,
      input  b_i,
      input  carry_i,
      output sum_o,
      output carry_o
   );

endinterface

// File: rtl/somador_slice.sv
// N-bit combinational add with carry-in, result packed as {carry_out, sum}.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: a, b (N-bit addends), cin (carry-in), res (N+1 bits: carry-out in MSB).
module somador_slice #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N:0]   res
);

   // Zero-extend everything to N+1 bits so the carry-out lands in res[N].
   assign res = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/somador_core.sv
// Three-stage registered adder: capture, low-slice add, high-slice add + output.
// Latency: operands before edge k are visible on sum_o/carry_o just after edge k+2.
// Backpressure: none; one result per cycle, outputs forced to 0 until primed.
// Ports: clk, rst_n (async active-low); bus (slave): a_i, b_i, carry_i in, sum_o, carry_o out.
module somador_core
   import somador_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SPLIT = SPLIT_DEF
) (
   input  logic      clk,
   input  logic      rst_n,
   somador_if.slave  bus
);

   localparam int HI = WIDTH - SPLIT;

   generate
      if (SPLIT < 1 || SPLIT >= WIDTH) begin : g_bad_split
         $error("somador_core: SPLIT must satisfy 1 <= SPLIT < WIDTH");
      end
   endgenerate

   // Stage 0: operand capture, isolates the pads from the adder logic.
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             c_r;

   // Stage 1: low slice already summed, high slice operands carried along.
   logic [SPLIT-1:0] lo_s;
   logic             lo_c;
   logic [HI-1:0]    a_hi;
   logic [HI-1:0]    b_hi;

   fill_state_t      fill_cnt;

   logic [SPLIT:0]   lo_res;
   logic [HI:0]      hi_res;

   somador_slice #(.N(SPLIT)) u_lo (
      .a   (a_r[SPLIT-1:0]),
      .b   (b_r[SPLIT-1:0]),
      .cin (c_r),
      .res (lo_res)
   );

   somador_slice #(.N(HI)) u_hi (
      .a   (a_hi),
      .b   (b_hi),
      .cin (lo_c),
      .res (hi_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r  <= '0;
         b_r  <= '0;
         c_r  <= 1'b0;
         lo_s <= '0;
         lo_c <= 1'b0;
         a_hi <= '0;
         b_hi <= '0;
      end else begin
         a_r  <= bus.a_i;
         b_r  <= bus.b_i;
         c_r  <= bus.carry_i;
         lo_s <= lo_res[SPLIT-1:0];
         lo_c <= lo_res[SPLIT];
         a_hi <= a_r[WIDTH-1:SPLIT];
         b_hi <= b_r[WIDTH-1:SPLIT];
      end
   end

   // Priming FSM with the output register. Outputs stay 0 until stage 1 holds
   // data captured after reset release, so pre-reset state never reaches the pads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt    <= EMPTY;
         bus.sum_o   <= '0;
         bus.carry_o <= 1'b0;
      end else begin
         case (fill_cnt)
            EMPTY:   fill_cnt <= FILL1;
            FILL1:   fill_cnt <= PRIMED;
            default: fill_cnt <= PRIMED;
         endcase

         if (fill_cnt == PRIMED) begin
            bus.sum_o   <= {hi_res[HI-1:0], lo_s};
            bus.carry_o <= hi_res[HI];
         end else begin
            bus.sum_o   <= '0;
            bus.carry_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_somador_core.sv
// Randomized scoreboard bench for somador_core, SPLIT = 4, 1 and 7 side by side.
// Latency: reference model delays {carry,sum}=a+b+cin by three edges after priming.
// Backpressure: none; one vector is driven every cycle.
module tb_somador_core;
   import somador_pkg::*;

   localparam int W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   logic [W-1:0] a_drv = '0;
   logic [W-1:0] b_drv = '0;
   logic         c_drv = 1'b0;

   somador_if #(.WIDTH(W)) bus_s4 ();
   somador_if #(.WIDTH(W)) bus_s1 ();
   somador_if #(.WIDTH(W)) bus_s7 ();

   assign bus_s4.a_i = a_drv;  assign bus_s4.b_i = b_drv;  assign bus_s4.carry_i = c_drv;
   assign bus_s1.a_i = a_drv;  assign bus_s1.b_i = b_drv;  assign bus_s1.carry_i = c_drv;
   assign bus_s7.a_i = a_drv;  assign bus_s7.b_i = b_drv;  assign bus_s7.carry_i = c_drv;

   somador_core #(.WIDTH(W), .SPLIT(4)) dut_s4 (.clk(clk), .rst_n(rst_n), .bus(bus_s4));
   somador_core #(.WIDTH(W), .SPLIT(1)) dut_s1 (.clk(clk), .rst_n(rst_n), .bus(bus_s1));
   somador_core #(.WIDTH(W), .SPLIT(7)) dut_s7 (.clk(clk), .rst_n(rst_n), .bus(bus_s7));

   logic [W:0] got_s4, got_s1, got_s7;
   assign got_s4 = {bus_s4.carry_o, bus_s4.sum_o};
   assign got_s1 = {bus_s1.carry_o, bus_s1.sum_o};
   assign got_s7 = {bus_s7.carry_o, bus_s7.sum_o};

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc_id = 0;

   logic [W:0] sb_q [$];   // expected {carry,sum} after the next edge
   logic [W:0] hist [$];   // true sums of the last LATENCY accepted vectors
   int         edges_since_rst = 0;

   task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got carry=%0b sum=0x%02h expected carry=%0b sum=0x%02h",
                  name, cyc_id, got[W], got[W-1:0], exp[W], exp[W-1:0]);
      end
   endtask

   // Drive one vector, predict the output seen after the coming edge, then
   // advance to the following falling edge.
   task automatic cyc(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W:0] full;
      logic [W:0] exp;
      a_drv = a;
      b_drv = b;
      c_drv = c;
      full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      if (!rst_n) begin
         hist.delete();
         edges_since_rst = 0;
         exp = '0;
      end else begin
         hist.push_back(full);
         if (hist.size() > LATENCY) void'(hist.pop_front());
         edges_since_rst++;
         exp = (edges_since_rst >= LATENCY) ? hist[0] : '0;
      end
      sb_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_cyc();
      cyc(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
          1'($urandom_range(0, 1)));
   endtask

   // Monitor: one expectation per edge, compared against all three splits.
   always @(posedge clk) begin : monitor
      logic [W:0] exp;
      #1;
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         check("split4", got_s4, exp);
         check("split1", got_s1, exp);
         check("split7", got_s7, exp);
         cyc_id++;
      end
   end

   initial begin
      #1 rst_n = 1'b0;

      // Held in reset with live operands: outputs must stay 0.
      repeat (3) cyc(8'h12, 8'h34, 1'b0);
      rst_n = 1'b1;
      // Two forced-zero edges, then 0x46.
      repeat (3) cyc(8'h12, 8'h34, 1'b0);

      // Directed corners, back to back.
      cyc(8'hFF, 8'h01, 1'b0);   // full wrap-around
      cyc(8'hFF, 8'hFF, 1'b1);
      cyc(8'h0F, 8'h01, 1'b0);   // carry crossing the low/high boundary
      cyc(8'h01, 8'h01, 1'b0);
      cyc(8'h80, 8'h80, 1'b0);
      cyc(8'h7F, 8'h00, 1'b1);
      repeat (4) rand_cyc();

      // Reset asserted between edges: outputs clear before the next edge.
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_split4", got_s4, '0);
      check("async_rst_split1", got_s1, '0);
      check("async_rst_split7", got_s7, '0);
      repeat (2) rand_cyc();
      rst_n = 1'b1;
      repeat (5) rand_cyc();

      // Random regression.
      repeat (10000) rand_cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
